// File: rtl/core_alu_issue_pkg.sv
// Shared constants for the ALU issue stage: ALU function codes, enable
// levels and the RV32I opcodes this unit decodes.
package core_alu_issue_pkg;

   localparam int XLEN       = 32;
   localparam int ALU_FUNC_W = 4;

   typedef enum logic [ALU_FUNC_W-1:0] {
      ALU_FUNC_ADD  = 4'd0,
      ALU_FUNC_SUB  = 4'd1,
      ALU_FUNC_SLL  = 4'd2,
      ALU_FUNC_SLT  = 4'd3,
      ALU_FUNC_SLTU = 4'd4,
      ALU_FUNC_XOR  = 4'd5,
      ALU_FUNC_SRL  = 4'd6,
      ALU_FUNC_SRA  = 4'd7,
      ALU_FUNC_OR   = 4'd8,
      ALU_FUNC_AND  = 4'd9
   } alu_func_e;

   localparam logic ALU_ENABLE  = 1'b1;
   localparam logic ALU_DISABLE = 1'b0;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

endpackage

// File: rtl/core_alu_issue_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into ALU operands,
// function code, destination and write enable.
module core_alu_issue_decode
   import core_alu_issue_pkg::*;
(
   input  logic [31:0]           inst,
   input  logic [31:0]           inst_pc,
   input  logic [31:0]           rs1_data,
   input  logic [31:0]           rs2_data,
   output logic [31:0]           op1,
   output logic [31:0]           op2,
   output logic [ALU_FUNC_W-1:0] func,
   output logic [4:0]            rd,
   output logic                  we,
   output logic                  illegal
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_u;

   assign w_opc   = inst[6:0];
   assign w_f3    = inst[14:12];
   assign w_f7    = inst[31:25];
   assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
   assign w_imm_u = {inst[31:12], 12'b0};

   always_comb begin
      op1     = rs1_data;
      op2     = rs2_data;
      func    = ALU_FUNC_ADD;
      illegal = 1'b0;
      rd      = inst[11:7];
      case (w_opc)
         OPC_OP: begin
            if (w_f7 == 7'b0000000) begin
               case (w_f3)
                  3'b000: func = ALU_FUNC_ADD;
                  3'b001: begin func = ALU_FUNC_SLL; op2 = {27'b0, rs2_data[4:0]}; end
                  3'b010: func = ALU_FUNC_SLT;
                  3'b011: func = ALU_FUNC_SLTU;
                  3'b100: func = ALU_FUNC_XOR;
                  3'b101: begin func = ALU_FUNC_SRL; op2 = {27'b0, rs2_data[4:0]}; end
                  3'b110: func = ALU_FUNC_OR;
                  default: func = ALU_FUNC_AND;
               endcase
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
               func = ALU_FUNC_SUB;
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
               func = ALU_FUNC_SRA;
               op2  = {27'b0, rs2_data[4:0]};
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            op2 = w_imm_i;
            case (w_f3)
               3'b000: func = ALU_FUNC_ADD;
               3'b010: func = ALU_FUNC_SLT;
               3'b011: func = ALU_FUNC_SLTU;
               3'b100: func = ALU_FUNC_XOR;
               3'b110: func = ALU_FUNC_OR;
               3'b111: func = ALU_FUNC_AND;
               3'b001: begin
                  func    = ALU_FUNC_SLL;
                  op2     = {27'b0, inst[24:20]};
                  illegal = (w_f7 != 7'b0000000);
               end
               default: begin
                  op2 = {27'b0, inst[24:20]};
                  if (w_f7 == 7'b0000000)      func = ALU_FUNC_SRL;
                  else if (w_f7 == 7'b0100000) func = ALU_FUNC_SRA;
                  else                         illegal = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            op1 = '0;
            op2 = w_imm_u;
         end
         OPC_AUIPC: begin
            op1 = inst_pc;
            op2 = w_imm_u;
         end
         default: illegal = 1'b1;
      endcase
      we = !illegal && (rd != 5'd0);
   end

endmodule

// File: rtl/core_alu_issue.sv
// Two-stage execute initiator: S1 presents operands to the external ALU,
// S2 captures the result and hands it to writeback under valid/ready.
module core_alu_issue
   import core_alu_issue_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   input  logic [31:0]           inst,
   input  logic [XLEN-1:0]       inst_pc,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   output logic                  alu_en,
   output logic [XLEN-1:0]       alu_op1,
   output logic [XLEN-1:0]       alu_op2,
   output logic [ALU_FUNC_W-1:0] alu_func,
   input  logic [XLEN-1:0]       alu_res,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_we,
   output logic [4:0]            wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic [XLEN-1:0]       wb_pc,
   output logic                  wb_illegal
);

   logic [XLEN-1:0]       w_op1, w_op2;
   logic [ALU_FUNC_W-1:0] w_func;
   logic [4:0]            w_rd;
   logic                  w_we, w_illegal;
   logic                  w_s1_adv, w_s2_adv, w_accept, w_s1_move;

   logic                  r_s1_valid, r_s1_we, r_s1_ill;
   logic [XLEN-1:0]       r_s1_op1, r_s1_op2, r_s1_pc;
   logic [ALU_FUNC_W-1:0] r_s1_func;
   logic [4:0]            r_s1_rd;

   logic                  r_s2_valid, r_s2_we, r_s2_ill;
   logic [XLEN-1:0]       r_s2_data, r_s2_pc;
   logic [4:0]            r_s2_rd;

   core_alu_issue_decode u_decode (
      .inst     (inst),
      .inst_pc  (inst_pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .op1      (w_op1),
      .op2      (w_op2),
      .func     (w_func),
      .rd       (w_rd),
      .we       (w_we),
      .illegal  (w_illegal)
   );

   assign w_s2_adv  = !r_s2_valid || wb_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign w_accept  = inst_valid && w_s1_adv;
   assign w_s1_move = r_s1_valid && w_s2_adv;

   // S1 only loads on accept, so operands stay bit-stable to the ALU while blocked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op1   <= '0;
         r_s1_op2   <= '0;
         r_s1_func  <= ALU_FUNC_ADD;
         r_s1_rd    <= '0;
         r_s1_we    <= 1'b0;
         r_s1_ill   <= 1'b0;
         r_s1_pc    <= RESET_PC;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_op1   <= w_op1;
         r_s1_op2   <= w_op2;
         r_s1_func  <= w_func;
         r_s1_rd    <= w_rd;
         r_s1_we    <= w_we;
         r_s1_ill   <= w_illegal;
         r_s1_pc    <= inst_pc;
      end else if (w_s1_move) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_rd    <= '0;
         r_s2_we    <= 1'b0;
         r_s2_ill   <= 1'b0;
         r_s2_pc    <= RESET_PC;
      end else if (flush) begin
         r_s2_valid <= 1'b0;
      end else if (w_s1_move) begin
         r_s2_valid <= 1'b1;
         r_s2_data  <= r_s1_ill ? '0 : alu_res;
         r_s2_rd    <= r_s1_rd;
         r_s2_we    <= r_s1_we;
         r_s2_ill   <= r_s1_ill;
         r_s2_pc    <= r_s1_pc;
      end else if (wb_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign inst_ready = w_s1_adv;
   assign alu_en     = r_s1_valid ? ALU_ENABLE : ALU_DISABLE;
   assign alu_op1    = r_s1_op1;
   assign alu_op2    = r_s1_op2;
   assign alu_func   = r_s1_func;
   assign wb_valid   = r_s2_valid;
   assign wb_we      = r_s2_we;
   assign wb_rd      = r_s2_rd;
   assign wb_data    = r_s2_data;
   assign wb_pc      = r_s2_pc;
   assign wb_illegal = r_s2_ill;

endmodule

// File: tb/tb_core_alu_issue.sv
// Scoreboard bench for core_alu_issue: stands in for core_alu, predicts each
// retirement from RV32I semantics and checks writeback order and contents.
module tb_core_alu_issue;
   import core_alu_issue_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, inst_valid = 1'b0, wb_ready = 1'b0;
   logic [31:0] inst = '0, inst_pc = '0, rs1_data = '0, rs2_data = '0;
   logic        inst_ready, alu_en, wb_valid, wb_we, wb_illegal;
   logic [31:0] alu_op1, alu_op2, alu_res, wb_data, wb_pc;
   logic [3:0]  alu_func;
   logic [4:0]  wb_rd;

   int errors = 0;
   int checks = 0;
   bit rand_ready = 1'b0;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;
   exp_t q[$];

   core_alu_issue #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .alu_en(alu_en), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .alu_res(alu_res),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_pc(wb_pc), .wb_illegal(wb_illegal)
   );

   always #5 clk = ~clk;

   // Stand-in for the external combinational core_alu
   always_comb begin
      alu_res = '0;
      case (alu_func)
         ALU_FUNC_ADD:  alu_res = alu_op1 + alu_op2;
         ALU_FUNC_SUB:  alu_res = alu_op1 - alu_op2;
         ALU_FUNC_SLL:  alu_res = alu_op1 << alu_op2[4:0];
         ALU_FUNC_SLT:  alu_res = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
         ALU_FUNC_SLTU: alu_res = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
         ALU_FUNC_XOR:  alu_res = alu_op1 ^ alu_op2;
         ALU_FUNC_SRL:  alu_res = alu_op1 >> alu_op2[4:0];
         ALU_FUNC_SRA:  alu_res = 32'($signed(alu_op1) >>> alu_op2[4:0]);
         ALU_FUNC_OR:   alu_res = alu_op1 | alu_op2;
         ALU_FUNC_AND:  alu_res = alu_op1 & alu_op2;
         default:       alu_res = '0;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   // Architectural result of one instruction, straight from the ISA rules
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [31:0]        imm, uimm;
      logic signed [31:0] sa;
      int                 sh_r, sh_i;
      e.rd = w[11:7]; e.pc = pc; e.ill = 1'b0; e.data = '0;
      imm  = {{20{w[31]}}, w[31:20]};
      uimm = {w[31:12], 12'b0};
      sa   = a;
      sh_r = int'(b[4:0]);
      sh_i = int'(w[24:20]);
      case (w[6:0])
         7'b0110011: begin
            if (w[31:25] == 7'h00) begin
               case (w[14:12])
                  3'd0: e.data = a + b;
                  3'd1: e.data = a << sh_r;
                  3'd2: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  3'd3: e.data = (a < b) ? 32'd1 : 32'd0;
                  3'd4: e.data = a ^ b;
                  3'd5: e.data = a >> sh_r;
                  3'd6: e.data = a | b;
                  default: e.data = a & b;
               endcase
            end else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) e.data = a - b;
            else if (w[31:25] == 7'h20 && w[14:12] == 3'd5)     e.data = 32'(sa >>> sh_r);
            else e.ill = 1'b1;
         end
         7'b0010011: begin
            case (w[14:12])
               3'd0: e.data = a + imm;
               3'd2: e.data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
               3'd3: e.data = (a < imm) ? 32'd1 : 32'd0;
               3'd4: e.data = a ^ imm;
               3'd6: e.data = a | imm;
               3'd7: e.data = a & imm;
               3'd1: if (w[31:25] == 7'h00) e.data = a << sh_i; else e.ill = 1'b1;
               default: begin
                  if (w[31:25] == 7'h00)      e.data = a >> sh_i;
                  else if (w[31:25] == 7'h20) e.data = 32'(sa >>> sh_i);
                  else                        e.ill = 1'b1;
               end
            endcase
         end
         7'b0110111: e.data = uimm;
         7'b0010111: e.data = pc + uimm;
         default:    e.ill = 1'b1;
      endcase
      if (e.ill) e.data = '0;
      e.we = !e.ill && (e.rd != 5'd0);
      return e;
   endfunction

   // Monitor / scoreboard, sampling mid-cycle
   logic        prev_wb_stall = 1'b0, prev_s1_stall = 1'b0;
   logic [31:0] prev_wb_data, prev_wb_pc, prev_op1, prev_op2;
   logic [4:0]  prev_wb_rd;
   logic [3:0]  prev_func;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_wb_stall = 1'b0;
         prev_s1_stall = 1'b0;
      end else begin
         if (prev_wb_stall) begin
            chk("wb_hold_valid", {31'b0, wb_valid}, 32'd1);
            chk("wb_hold_data", wb_data, prev_wb_data);
            chk("wb_hold_pc", wb_pc, prev_wb_pc);
            chk("wb_hold_rd", {27'b0, wb_rd}, {27'b0, prev_wb_rd});
         end
         if (prev_s1_stall) begin
            chk("alu_hold_op1", alu_op1, prev_op1);
            chk("alu_hold_op2", alu_op2, prev_op2);
            chk("alu_hold_func", {28'b0, alu_func}, {28'b0, prev_func});
         end
         if (wb_valid && wb_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wb_unexpected: retirement pc %h with nothing outstanding", wb_pc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
               chk("wb_we", {31'b0, wb_we}, {31'b0, e.we});
               chk("wb_illegal", {31'b0, wb_illegal}, {31'b0, e.ill});
               chk("wb_data", wb_data, e.data);
               chk("wb_pc", wb_pc, e.pc);
            end
         end
         if (inst_valid && inst_ready && !flush) q.push_back(model(inst, inst_pc, rs1_data, rs2_data));
         if (flush) q.delete();
         prev_wb_stall = wb_valid && !wb_ready && !flush;
         prev_s1_stall = alu_en && !inst_ready && !flush;
         prev_wb_data  = wb_data;
         prev_wb_pc    = wb_pc;
         prev_wb_rd    = wb_rd;
         prev_op1      = alu_op1;
         prev_op2      = alu_op2;
         prev_func     = alu_func;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         wb_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Offer one instruction; returns 1 time unit after the accepting edge
   task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
      bit acc;
      acc = 1'b0;
      inst = w; inst_pc = pc; rs1_data = a; rs2_data = b; inst_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = inst_ready;
         @(posedge clk);
         #1;
      end
      inst_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: inst %h never accepted", w);
      end
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      wb_ready   = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] f7;
      logic [2:0] f3;
      int         k, s;
      k  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      s  = $urandom_range(0, 3);
      f7 = (s < 2) ? 7'h00 : (s == 2) ? 7'h20 : 7'($urandom);
      case (k)
         0, 1, 2, 3: return r_type(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), OPC_OP);
         4, 5, 6: begin
            if (f3 == 3'd1 || f3 == 3'd5)
               return i_type({f7, 5'($urandom)}, 5'($urandom), f3, 5'($urandom), OPC_OPIMM);
            return i_type(12'($urandom), 5'($urandom), f3, 5'($urandom), OPC_OPIMM);
         end
         7: return u_type(20'($urandom), 5'($urandom), OPC_LUI);
         8: return u_type(20'($urandom), 5'($urandom), OPC_AUIPC);
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 4))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #12;
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_alu_en", {31'b0, alu_en}, 32'd0);
      chk("rst_alu_func", {28'b0, alu_func}, {28'b0, ALU_FUNC_ADD});
      chk("rst_alu_op1", alu_op1, 32'd0);
      chk("rst_wb_pc", wb_pc, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_inst_ready", {31'b0, inst_ready}, 32'd1);

      wb_ready = 1'b1;
      send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP), 32'h40, 32'd5, 32'd7);
      chk("add_alu_en", {31'b0, alu_en}, 32'd1);
      chk("add_alu_func", {28'b0, alu_func}, {28'b0, ALU_FUNC_ADD});
      @(posedge clk); #1;
      chk("add_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("add_wb_data", wb_data, 32'd12);
      chk("add_wb_rd", {27'b0, wb_rd}, 32'd3);

      send(i_type(12'h404, 5'd1, 3'd5, 5'd4, OPC_OPIMM), 32'h44, 32'h8000_0000, 32'd0);
      chk("srai_op2", alu_op2, 32'd4);
      send(r_type(7'h20, 5'd2, 5'd1, 3'd5, 5'd4, OPC_OP), 32'h48, 32'h8000_0000, 32'hFFFF_FF24);
      chk("sra_op2", alu_op2, 32'd4);
      @(posedge clk); #1;
      chk("sra_wb_data", wb_data, 32'hF800_0000);

      send(u_type(20'h12345, 5'd5, OPC_AUIPC), 32'h100, 32'd0, 32'd0);
      @(posedge clk); #1;
      chk("auipc_wb_data", wb_data, 32'h1234_5100);
      send(u_type(20'h00001, 5'd0, OPC_LUI), 32'h104, 32'd9, 32'd9);
      @(posedge clk); #1;
      chk("lui_x0_we", {31'b0, wb_we}, 32'd0);
      chk("lui_x0_data", wb_data, 32'h0000_1000);
      send(32'h0000_006F, 32'h108, 32'd1, 32'd2);
      @(posedge clk); #1;
      chk("jal_illegal", {31'b0, wb_illegal}, 32'd1);
      chk("jal_data", wb_data, 32'd0);
      send(r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd6, OPC_OP), 32'h10C, 32'd3, 32'd4);
      @(posedge clk); #1;
      chk("mul_illegal", {31'b0, wb_illegal}, 32'd1);
      drain();

      wb_ready = 1'b0;
      fork
         begin
            send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, OPC_OP), 32'h200, 32'd1, 32'd2);
            send(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd8, OPC_OP), 32'h204, 32'd1, 32'd2);
            chk("b2b_inst_ready", {31'b0, inst_ready}, 32'd0);
            send(i_type(12'hFFF, 5'd1, 3'd4, 5'd9, OPC_OPIMM), 32'h208, 32'h0F0F_0F0F, 32'd0);
            send(u_type(20'hABCDE, 5'd10, OPC_LUI), 32'h20C, 32'd0, 32'd0);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            wb_ready = 1'b1;
         end
      join
      drain();

      wb_ready = 1'b0;
      send(r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd11, OPC_OP), 32'h300, 32'hFF, 32'h0F);
      send(r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd12, OPC_OP), 32'h304, 32'hF0, 32'h0F);
      inst = u_type(20'h00042, 5'd13, OPC_LUI); inst_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; inst_valid = 1'b0;
      chk("flush_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("flush_alu_en", {31'b0, alu_en}, 32'd0);
      drain();

      for (int n = 0; n < 300; n++) begin
         rand_ready = 1'b1;
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
         send(rand_inst(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rand_val(), rand_val());
      end
      drain();

      wb_ready = 1'b0;
      send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd14, OPC_OP), 32'h400, 32'd1, 32'd1);
      send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd15, OPC_OP), 32'h404, 32'd2, 32'd2);
      inst_valid = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      inst_valid = 1'b0;
      chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("arst_alu_en", {31'b0, alu_en}, 32'd0);
      chk("arst_wb_pc", wb_pc, 32'd0);
      chk("arst_wb_data", wb_data, 32'd0);
      chk("arst_alu_op2", alu_op2, 32'd0);
      chk("arst_alu_func", {28'b0, alu_func}, {28'b0, ALU_FUNC_ADD});
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_inst_ready", {31'b0, inst_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
